// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter and write sequencer in front of a shared W-bit register.
// One requester is granted per three-cycle IDLE -> GRANT -> RELEASE round.
module dff_reg_arbiter #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   wr_data,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     ack,
    output logic [W-1:0]     q,
    output logic             busy,
    output logic [IW-1:0]    owner
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n, owner_n;
    logic [N-1:0]    gnt_n, ack_n;
    logic [W-1:0]    q_n;
    logic            busy_n;

    logic [IW-1:0]   sel, cand;
    logic [IW:0]     sum;
    logic            found;

    // Rotating scan: first set request after the last-served index, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        sum   = '0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N))
                sum = sum - (IW+1)'(N);
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        ack_n   = ack;
        q_n     = q;
        busy_n  = busy;
        owner_n = owner;
        ptr_n   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_n   = ONE << sel;
                    owner_n = sel;
                    busy_n  = 1'b1;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                // Only the owner's request and data matter; a dropped request still rotates priority.
                if (req[owner]) begin
                    q_n   = wr_data[int'(owner)*W +: W];
                    ack_n = ONE << owner;
                end
                ptr_n   = owner;
                gnt_n   = '0;
                state_n = RELEASE;
            end
            RELEASE: begin
                ack_n   = '0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                gnt_n   = '0;
                ack_n   = '0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= '0;
            ack   <= '0;
            q     <= '0;
            busy  <= 1'b0;
            owner <= '0;
            ptr   <= IW'(N-1);
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            ack   <= ack_n;
            q     <= q_n;
            busy  <= busy_n;
            owner <= owner_n;
            ptr   <= ptr_n;
        end
    end

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Self-checking bench for dff_reg_arbiter: directed scenarios plus randomized rounds
// compared against a transaction-level round-robin model.
module tb_dff_reg_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*W-1:0]   wr_data;
    logic [N-1:0]     gnt;
    logic [N-1:0]     ack;
    logic [W-1:0]     q;
    logic             busy;
    logic [IW-1:0]    owner;

    int compared   = 0;
    int mismatched = 0;

    // Model state: last-served requester and the value the register should hold.
    int          mptr;
    logic [W-1:0] mq;

    dff_reg_arbiter #(.N(N), .W(W), .IW(IW)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr_data (wr_data),
        .gnt     (gnt),
        .ack     (ack),
        .q       (q),
        .busy    (busy),
        .owner   (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input int p, input logic [N-1:0] r);
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (p + k) % N;
            if (r[idx] === 1'b1) return idx;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        req     = '0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({gnt, ack, busy, owner, q} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: got gnt=%b ack=%b busy=%b owner=%0d q=%h, want all zero", gnt, ack, busy, owner, q);
        end
        reset = 1'b1;
        tick();
        compared++;
        if (gnt !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_gnt: got %b want 0000", gnt); end
        compared++;
        if (ack !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_ack: got %b want 0000", ack); end
        compared++;
        if (q !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_q: got %h want 00", q); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        compared++;
        if (owner !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_owner: got %0d want 0", owner); end
        mptr = N - 1;
        mq   = '0;
    endtask

    task automatic test_single();
        wr_data        = {$urandom, $urandom};
        wr_data[23:16] = 8'hA5;
        req            = 4'b0100;
        tick();
        compared++;
        if (gnt !== 4'b0100) begin mismatched++; $display("[TB] FAIL single_gnt: got %b want 0100", gnt); end
        compared++;
        if (owner !== 2'd2 || busy !== 1'b1 || ack !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL single_grant_state: got owner=%0d busy=%b ack=%b want 2/1/0000", owner, busy, ack);
        end
        tick();
        compared++;
        if (q !== 8'hA5) begin mismatched++; $display("[TB] FAIL single_q: got %h want a5", q); end
        compared++;
        if (ack !== 4'b0100 || gnt !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL single_ack: got ack=%b gnt=%b want 0100/0000", ack, gnt);
        end
        tick();
        compared++;
        if (busy !== 1'b0 || ack !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL single_release: got busy=%b ack=%b want 0/0000", busy, ack);
        end
        req  = '0;
        mq   = 8'hA5;
        mptr = 2;
    endtask

    task automatic test_round_robin();
        int exp;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        mptr  = N - 1;
        mq    = '0;
        req     = 4'b1111;
        wr_data = 32'h44332211;
        for (int g = 0; g < 5; g++) begin
            exp = pick(mptr, req);
            tick();
            compared++;
            if (gnt !== (4'b0001 << exp)) begin mismatched++; $display("[TB] FAIL rr_gnt%0d: got %b want %b", g, gnt, 4'b0001 << exp); end
            compared++;
            if (owner !== IW'(g % N)) begin mismatched++; $display("[TB] FAIL rr_order%0d: got %0d want %0d", g, owner, g % N); end
            tick();
            mq   = wr_data[exp*W +: W];
            mptr = exp;
            compared++;
            if (q !== mq || ack !== (4'b0001 << exp)) begin
                mismatched++;
                $display("[TB] FAIL rr_commit%0d: got q=%h ack=%b want q=%h ack=%b", g, q, ack, mq, 4'b0001 << exp);
            end
            if (g == 4) req = '0;
            tick();
            compared++;
            if (busy !== 1'b0 || gnt !== 4'b0000) begin
                mismatched++;
                $display("[TB] FAIL rr_idle%0d: got busy=%b gnt=%b want 0/0000", g, busy, gnt);
            end
        end
    endtask

    task automatic test_alternate();
        int exp;
        req     = 4'b0101;
        wr_data = {$urandom, $urandom};
        for (int g = 0; g < 4; g++) begin
            exp = pick(mptr, req);
            tick();
            compared++;
            if (owner !== ((g % 2 == 0) ? 2'd2 : 2'd0) || gnt !== (4'b0001 << exp)) begin
                mismatched++;
                $display("[TB] FAIL alt_grant%0d: got owner=%0d gnt=%b want owner=%0d", g, owner, gnt, (g % 2 == 0) ? 2 : 0);
            end
            tick();
            mq   = wr_data[exp*W +: W];
            mptr = exp;
            compared++;
            if (q !== mq || ack !== (4'b0001 << exp)) begin
                mismatched++;
                $display("[TB] FAIL alt_commit%0d: got q=%h ack=%b want q=%h", g, q, ack, mq);
            end
            if (g == 3) req = '0;
            tick();
        end
    endtask

    task automatic test_abort();
        req           = 4'b0010;
        wr_data       = {$urandom, $urandom};
        wr_data[15:8] = ~mq;
        tick();
        compared++;
        if (gnt !== 4'b0010) begin mismatched++; $display("[TB] FAIL abort_gnt: got %b want 0010", gnt); end
        req = 4'b0000;
        tick();
        compared++;
        if (q !== mq || ack !== 4'b0000 || gnt !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL abort_hold: got q=%h ack=%b gnt=%b want q=%h ack=0000 gnt=0000", q, ack, gnt, mq);
        end
        mptr = 1;
        tick();
        compared++;
        if (ack !== 4'b0000 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_release: got ack=%b busy=%b want 0000/0", ack, busy);
        end
        req            = 4'b0111;
        wr_data[23:16] = 8'h5A;
        tick();
        compared++;
        if (gnt !== 4'b0100) begin mismatched++; $display("[TB] FAIL abort_next_gnt: got %b want 0100", gnt); end
        tick();
        compared++;
        if (q !== 8'h5A || ack !== 4'b0100) begin
            mismatched++;
            $display("[TB] FAIL abort_next_commit: got q=%h ack=%b want 5a/0100", q, ack);
        end
        mq   = 8'h5A;
        mptr = 2;
        req  = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        req          = 4'b0001;
        wr_data[7:0] = 8'hFF;
        tick();
        compared++;
        if (gnt !== 4'b0001) begin mismatched++; $display("[TB] FAIL rmid_gnt: got %b want 0001", gnt); end
        #3;
        reset = 1'b0;
        #1;
        compared++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || q !== 8'h00 || ack !== 4'b0000 || owner !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL rmid_async: got gnt=%b busy=%b q=%h ack=%b owner=%0d want all zero", gnt, busy, q, ack, owner);
        end
        @(posedge clk);
        #1;
        compared++;
        if (ack !== 4'b0000 || q !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL rmid_no_commit: got ack=%b q=%h want 0000/00", ack, q);
        end
        reset = 1'b1;
        mptr  = N - 1;
        mq    = '0;
        req   = 4'b1111;
        tick();
        compared++;
        if (gnt !== 4'b0001) begin mismatched++; $display("[TB] FAIL rmid_priority: got %b want 0001", gnt); end
        tick();
        compared++;
        if (q !== 8'hFF || ack !== 4'b0001) begin
            mismatched++;
            $display("[TB] FAIL rmid_commit: got q=%h ack=%b want ff/0001", q, ack);
        end
        mq   = 8'hFF;
        mptr = 0;
        req  = '0;
        tick();
    endtask

    task automatic test_random();
        int            exp;
        bit            abort;
        logic [N-1:0]  r;
        logic [W-1:0]  odata;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                req = '0;
                tick();
                compared++;
                if (gnt !== 4'b0000 || busy !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL rnd_idle%0d: got gnt=%b busy=%b want 0000/0", t, gnt, busy);
                end
            end
            r       = 4'($urandom_range(1, 15));
            req     = r;
            wr_data = {$urandom, $urandom};
            exp     = pick(mptr, r);
            odata   = wr_data[exp*W +: W];
            tick();
            compared++;
            if (gnt !== (4'b0001 << exp) || owner !== IW'(exp) || busy !== 1'b1 || ack !== 4'b0000) begin
                mismatched++;
                $display("[TB] FAIL rnd_grant%0d: got gnt=%b owner=%0d busy=%b ack=%b want owner=%0d", t, gnt, owner, busy, ack, exp);
            end
            abort = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if (i == exp) begin
                    req[i] = !abort;
                end else begin
                    req[i]         = ($urandom_range(0, 1) == 0) ? 1'bx : 1'($urandom_range(0, 1));
                    wr_data[i*W +: W] = ($urandom_range(0, 1) == 0) ? 8'hxx : 8'($urandom);
                end
            end
            tick();
            mptr = exp;
            if (!abort) mq = odata;
            compared++;
            if (q !== mq || ack !== (abort ? 4'b0000 : (4'b0001 << exp)) || gnt !== 4'b0000) begin
                mismatched++;
                $display("[TB] FAIL rnd_commit%0d: got q=%h ack=%b gnt=%b want q=%h abort=%0d", t, q, ack, gnt, mq, abort);
            end
            req = '0;
            tick();
            compared++;
            if (busy !== 1'b0 || ack !== 4'b0000 || q !== mq) begin
                mismatched++;
                $display("[TB] FAIL rnd_release%0d: got busy=%b ack=%b q=%h want 0/0000/%h", t, busy, ack, q, mq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_alternate();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
